// File: rtl/text_mode_pkg.sv
// Shared definitions for the text-mode index scanner.
//
// Holds the default display/glyph geometry, the derivation functions for the
// character grid and field widths, and the output bundle typedef for the
// default geometry.
//
// Optional feature macro: TEXT_MODE_DOUBLE_SCAN_EN (vertical 2x scale; each
// glyph line is emitted on two consecutive scan lines).
package text_mode_pkg;

    localparam int unsigned H_RES_DEF   = 640;
    localparam int unsigned V_RES_DEF   = 480;
    localparam int unsigned GLYPH_W_DEF = 8;
    localparam int unsigned GLYPH_H_DEF = 16;

`ifdef TEXT_MODE_DOUBLE_SCAN_EN
    localparam int unsigned VSCALE = 2;
`else
    localparam int unsigned VSCALE = 1;
`endif

    // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : int'($clog2(v));
    endfunction

    function automatic int unsigned calc_cols(input int unsigned h_res, input int unsigned glyph_w);
        return h_res / glyph_w;
    endfunction

    function automatic int unsigned calc_rows(input int unsigned v_res, input int unsigned glyph_h);
        return v_res / (glyph_h * VSCALE);
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned h_res, input int unsigned v_res,
                                               input int unsigned glyph_w,
                                               input int unsigned glyph_h);
        return clog2_min1(calc_cols(h_res, glyph_w) * calc_rows(v_res, glyph_h));
    endfunction

    function automatic int unsigned calc_gxy_w(input int unsigned glyph_w,
                                               input int unsigned glyph_h);
        return clog2_min1(glyph_w * glyph_h);
    endfunction

    localparam int unsigned DEF_IDX_W = calc_idx_w(H_RES_DEF, V_RES_DEF, GLYPH_W_DEF, GLYPH_H_DEF);
    localparam int unsigned DEF_GXY_W = calc_gxy_w(GLYPH_W_DEF, GLYPH_H_DEF);
    localparam int unsigned DEF_COL_W = clog2_min1(calc_cols(H_RES_DEF, GLYPH_W_DEF));
    localparam int unsigned DEF_ROW_W = clog2_min1(calc_rows(V_RES_DEF, GLYPH_H_DEF));

    // Output bundle at the default geometry.
    typedef struct packed {
        logic [DEF_IDX_W-1:0] char_idx;
        logic [DEF_GXY_W-1:0] glyph_xy;
        logic [DEF_COL_W-1:0] col;
        logic [DEF_ROW_W-1:0] row;
        logic                 eol;
        logic                 eof;
    } scan_out_t;

endpackage

// File: rtl/text_mode_index_scanner_if.sv
// Pixel-in / index-out handshake bundle of the text-mode index scanner.
//
// Signals:
//   pix_valid_i  upstream offers next pixel
//   pix_ready_o  scanner accepts pixel this cycle
//   idx_valid_o  output fields valid
//   idx_ready_i  downstream accepts output
//   char_idx_o   character-cell linear index (row*COLS+col)
//   glyph_xy_o   pixel offset inside the glyph (gy*GLYPH_W+gx)
//   char_col_o   character column
//   char_row_o   character row
//   eol_o        output is last pixel of a line
//   eof_o        output is last pixel of the frame
// Modports: slave = scanner side, master = environment side.
interface text_mode_index_scanner_if #(
    parameter int unsigned IDX_W = 12,
    parameter int unsigned GXY_W = 7,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5
);
    logic             pix_valid_i;
    logic             pix_ready_o;
    logic             idx_valid_o;
    logic             idx_ready_i;
    logic [IDX_W-1:0] char_idx_o;
    logic [GXY_W-1:0] glyph_xy_o;
    logic [COL_W-1:0] char_col_o;
    logic [ROW_W-1:0] char_row_o;
    logic             eol_o;
    logic             eof_o;

    modport slave (
        input  pix_valid_i, idx_ready_i,
        output pix_ready_o, idx_valid_o, char_idx_o, glyph_xy_o, char_col_o, char_row_o,
               eol_o, eof_o
    );

    modport master (
        output pix_valid_i, idx_ready_i,
        input  pix_ready_o, idx_valid_o, char_idx_o, glyph_xy_o, char_col_o, char_row_o,
               eol_o, eof_o
    );
endinterface

// File: rtl/text_mode_wrap_counter.sv
// Wrapping up-counter used for the scanner's gx/col/gy/row positions.
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (count -> 0)
//   en_i     advance by one this cycle
//   clr_i    synchronous clear, wins over en_i
//   max_i    last value before wrapping to 0
//   count_o  current count
//   wrap_o   count is at max_i (next advance wraps)
module text_mode_wrap_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);
    logic [W-1:0] count_q;

    assign wrap_o  = (count_q == max_i);
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= wrap_o ? '0 : count_q + 1'b1;
        end
    end
endmodule

// File: rtl/text_mode_index_scanner.sv
// Text-mode index scanner: walks the active area in raster order, one pixel
// per accepted handshake, and emits the character-cell index plus the pixel
// offset inside the glyph. No multipliers: the index is row_base + col, with
// row_base accumulated in steps of COLS.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   sof_i  synchronous start-of-frame restart; blocks acceptance that cycle
//   bus    text_mode_index_scanner_if.slave (pixel handshake in, index out)
//
// Optional feature macro: TEXT_MODE_DOUBLE_SCAN_EN (each glyph line spans two
// scan lines; glyph_xy uses gy>>1).
module text_mode_index_scanner
    import text_mode_pkg::*;
#(
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned GLYPH_W = GLYPH_W_DEF,
    parameter int unsigned GLYPH_H = GLYPH_H_DEF
) (
    input logic                      clk_i,
    input logic                      rst_i,
    input logic                      sof_i,
    text_mode_index_scanner_if.slave bus
);
    localparam int unsigned COLS  = calc_cols(H_RES, GLYPH_W);
    localparam int unsigned ROWS  = calc_rows(V_RES, GLYPH_H);
    localparam int unsigned IDX_W = calc_idx_w(H_RES, V_RES, GLYPH_W, GLYPH_H);
    localparam int unsigned GXY_W = calc_gxy_w(GLYPH_W, GLYPH_H);
    localparam int unsigned COL_W = clog2_min1(COLS);
    localparam int unsigned ROW_W = clog2_min1(ROWS);
    localparam int unsigned GX_W  = $clog2(GLYPH_W);
    localparam int unsigned GYE_W = $clog2(GLYPH_H);
    localparam int unsigned GY_W  = $clog2(GLYPH_H * VSCALE);

    logic             pix_ready, accept;
    logic [GX_W-1:0]  gx;
    logic [COL_W-1:0] col;
    logic [GY_W-1:0]  gy;
    logic [GYE_W-1:0] gy_eff;
    logic [ROW_W-1:0] row;
    logic             gx_wrap, col_wrap, gy_wrap, row_wrap;
    logic             col_en, gy_en, row_en;
    logic [IDX_W-1:0] row_base_q;

    logic             idx_valid_q;
    logic [IDX_W-1:0] char_idx_q;
    logic [GXY_W-1:0] glyph_xy_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             eol_q, eof_q;

    assign pix_ready = !sof_i && (!idx_valid_q || bus.idx_ready_i);
    assign accept    = bus.pix_valid_i && pix_ready;

    // Carry chain: each stage advances when every lower stage wraps.
    assign col_en = accept && gx_wrap;
    assign gy_en  = col_en && col_wrap;
    assign row_en = gy_en && gy_wrap;

`ifdef TEXT_MODE_DOUBLE_SCAN_EN
    assign gy_eff = gy[GY_W-1:1];
`else
    assign gy_eff = gy;
`endif

    text_mode_wrap_counter #(.W(GX_W)) u_gx (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (accept),
        .clr_i  (sof_i),
        .max_i  (GX_W'(GLYPH_W - 1)),
        .count_o(gx),
        .wrap_o (gx_wrap)
    );

    text_mode_wrap_counter #(.W(COL_W)) u_col (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (col_en),
        .clr_i  (sof_i),
        .max_i  (COL_W'(COLS - 1)),
        .count_o(col),
        .wrap_o (col_wrap)
    );

    text_mode_wrap_counter #(.W(GY_W)) u_gy (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (gy_en),
        .clr_i  (sof_i),
        .max_i  (GY_W'(GLYPH_H * VSCALE - 1)),
        .count_o(gy),
        .wrap_o (gy_wrap)
    );

    text_mode_wrap_counter #(.W(ROW_W)) u_row (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (row_en),
        .clr_i  (sof_i),
        .max_i  (ROW_W'(ROWS - 1)),
        .count_o(row),
        .wrap_o (row_wrap)
    );

    // row_base tracks row*COLS; it restarts together with the row counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_base_q <= '0;
        end else if (sof_i) begin
            row_base_q <= '0;
        end else if (row_en) begin
            row_base_q <= row_wrap ? '0 : row_base_q + IDX_W'(COLS);
        end
    end

    // Output register: describes the pixel just accepted (eol/eof included).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_valid_q <= 1'b0;
            char_idx_q  <= '0;
            glyph_xy_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else if (sof_i) begin
            idx_valid_q <= 1'b0;
        end else if (accept) begin
            idx_valid_q <= 1'b1;
            char_idx_q  <= row_base_q + IDX_W'(col);
            glyph_xy_q  <= {gy_eff, gx};
            col_q       <= col;
            row_q       <= row;
            eol_q       <= gx_wrap && col_wrap;
            eof_q       <= gx_wrap && col_wrap && gy_wrap && row_wrap;
        end else if (bus.idx_ready_i) begin
            idx_valid_q <= 1'b0;
        end
    end

    assign bus.pix_ready_o = pix_ready;
    assign bus.idx_valid_o = idx_valid_q;
    assign bus.char_idx_o  = char_idx_q;
    assign bus.glyph_xy_o  = glyph_xy_q;
    assign bus.char_col_o  = col_q;
    assign bus.char_row_o  = row_q;
    assign bus.eol_o       = eol_q;
    assign bus.eof_o       = eof_q;
endmodule
